cos_th2_fixed: RTL and testbench

COS_TH2_FIXED -- requirements
Module: cos_th2_fixed

---
 rtl/cos_th2_fixed_pkg.sv | 28 ++
 rtl/ufix_seq_divider.sv | 55 +++++
 rtl/cos_th2_fixed.sv | 150 +++++++++++++++
 tb/tb_cos_th2_fixed.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cos_th2_fixed_pkg.sv
// Shared types and width helpers for the cos(theta2) fixed-point block.
package cos_th2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    SUM,
    CHECK,
    DIV,
    FINISH
  } state_t;

  // Full-width product of two WIDTH-bit magnitudes.
  function automatic int unsigned prod_w(input int unsigned width);
    return 2 * width;
  endfunction

  // Signed numerator x^2 + y^2 - l1^2 - l2^2 with headroom for the sum.
  function automatic int unsigned num_w(input int unsigned width);
    return 2 * width + 2;
  endfunction

  // Unsigned denominator 2*l1*l2.
  function automatic int unsigned den_w(input int unsigned width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/ufix_seq_divider.sv
// Restoring divider, one quotient bit per cycle, MSB first.
// done is high during the final iteration; quotient is valid from the next cycle.
module ufix_seq_divider #(
  parameter int unsigned NUM_W  = 82,
  parameter int unsigned Q_BITS = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_W-1:0]  dividend,
  input  logic [NUM_W-1:0]  divisor,
  output logic [Q_BITS-1:0] quotient,
  output logic              done
);
  localparam int unsigned SH_W  = NUM_W + Q_BITS;
  localparam int unsigned CNT_W = $clog2(Q_BITS + 1);

  logic [SH_W-1:0]  rem;
  logic [SH_W-1:0]  dsh;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  // Divisor is pre-shifted to the top quotient position and walked down one bit per step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem      <= '0;
      dsh      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      quotient <= '0;
    end else if (start) begin
      rem      <= SH_W'(dividend);
      dsh      <= SH_W'(divisor) << (Q_BITS - 1);
      cnt      <= CNT_W'(Q_BITS);
      busy     <= 1'b1;
      quotient <= '0;
    end else if (busy) begin
      if (rem >= dsh) begin
        rem      <= rem - dsh;
        quotient <= {quotient[Q_BITS-2:0], 1'b1};
      end else begin
        quotient <= {quotient[Q_BITS-2:0], 1'b0};
      end
      dsh <= dsh >> 1;
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) busy <= 1'b0;
    end
  end

  // Flag the last iteration so the caller can leave its wait state on time.
  always_comb begin
    done = busy && (cnt == CNT_W'(1));
  end

endmodule

// File: rtl/cos_th2_fixed.sv
// cos(theta2) = (x^2 + y^2 - l1^2 - l2^2) / (2*l1*l2) for a two-link arm, fixed-point QFRAC.
module cos_th2_fixed
  import cos_th2_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] l1,
  input  logic [WIDTH-1:0] l2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] cos_out,
  output logic             unreachable,
  output logic             div_zero
);
  localparam int unsigned PROD_W = prod_w(WIDTH);
  localparam int unsigned NUM_W  = num_w(WIDTH);
  localparam int unsigned DEN_W  = den_w(WIDTH);
  localparam int unsigned DIV_W  = NUM_W + FRAC;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;

  state_t state, state_nx;

  logic [WIDTH-1:0]  rx, ry, rl1, rl2;
  logic [2:0]        mcnt;
  logic [PROD_W-1:0] px, py, pl1, pl2, p12;
  logic [NUM_W-1:0]  num, absn;
  logic [DEN_W-1:0]  den;
  logic              neg_p, unr_p, dz_p;
  logic [WIDTH-1:0]  ax, ay, mul_a, mul_b;
  logic [PROD_W-1:0] mul_p;
  logic              div_start, div_done;
  logic [FRAC:0]     quo;
  logic [WIDTH-1:0]  q_ext;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state plus the handshake/control strobes decoded from state.
  always_comb begin
    state_nx  = state;
    ready     = 1'b0;
    div_start = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nx = MUL;
      end
      MUL:    if (mcnt == 3'd4) state_nx = SUM;
      SUM:    state_nx = CHECK;
      CHECK: begin
        div_start = 1'b1;
        state_nx  = DIV;
      end
      DIV:    if (div_done) state_nx = FINISH;
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Signed inputs are squared through their magnitudes so one unsigned multiplier serves all five products.
  always_comb begin
    ax    = rx[WIDTH-1] ? -rx : rx;
    ay    = ry[WIDTH-1] ? -ry : ry;
    mul_a = rl1;
    mul_b = rl2;
    case (mcnt)
      3'd0: begin mul_a = ax;  mul_b = ax;  end
      3'd1: begin mul_a = ay;  mul_b = ay;  end
      3'd2: begin mul_a = rl1; mul_b = rl1; end
      3'd3: begin mul_a = rl2; mul_b = rl2; end
      default: begin mul_a = rl1; mul_b = rl2; end
    endcase
    mul_p = PROD_W'(mul_a) * PROD_W'(mul_b);
    absn  = num[NUM_W-1] ? -num : num;
    q_ext = WIDTH'(quo);
  end

  ufix_seq_divider #(
    .NUM_W  (DIV_W),
    .Q_BITS (FRAC + 1)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (DIV_W'(absn) << FRAC),
    .divisor  (DIV_W'(den)),
    .quotient (quo),
    .done     (div_done)
  );

  // Operand capture, product accumulation, range check and result publication.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx <= '0; ry <= '0; rl1 <= '0; rl2 <= '0;
      mcnt <= '0;
      px <= '0; py <= '0; pl1 <= '0; pl2 <= '0; p12 <= '0;
      num <= '0; den <= '0;
      neg_p <= 1'b0; unr_p <= 1'b0; dz_p <= 1'b0;
      done <= 1'b0; cos_out <= '0; unreachable <= 1'b0; div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rx <= x; ry <= y; rl1 <= l1; rl2 <= l2;
            mcnt <= '0;
          end
        end
        MUL: begin
          case (mcnt)
            3'd0: px  <= mul_p;
            3'd1: py  <= mul_p;
            3'd2: pl1 <= mul_p;
            3'd3: pl2 <= mul_p;
            default: p12 <= mul_p;
          endcase
          mcnt <= mcnt + 3'd1;
        end
        SUM: begin
          num <= NUM_W'(px) + NUM_W'(py) - NUM_W'(pl1) - NUM_W'(pl2);
          den <= {p12, 1'b0};
        end
        CHECK: begin
          neg_p <= num[NUM_W-1];
          dz_p  <= (den == '0);
          unr_p <= (den != '0) && (NUM_W'(den) < absn);
        end
        FINISH: begin
          done        <= 1'b1;
          unreachable <= unr_p;
          div_zero    <= dz_p;
          if (dz_p)       cos_out <= '0;
          else if (unr_p) cos_out <= neg_p ? -ONE : ONE;
          else            cos_out <= neg_p ? -q_ext : q_ext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cos_th2_fixed.sv
// Self-checking bench for cos_th2_fixed: directed table, multi-cycle corner sequences, random vs model.
module tb_cos_th2_fixed;
  localparam int unsigned W   = 32;
  localparam int unsigned F   = 16;
  localparam int          LAT = F + 9;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] x, y, l1, l2;
  logic         ready, done, unreachable, div_zero;
  logic [W-1:0] cos_out;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_prev = '0;

  always #5 clk = ~clk;

  cos_th2_fixed #(
    .WIDTH (W),
    .FRAC  (F)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .x           (x),
    .y           (y),
    .l1          (l1),
    .l2          (l2),
    .ready       (ready),
    .done        (done),
    .cos_out     (cos_out),
    .unreachable (unreachable),
    .div_zero    (div_zero)
  );

  typedef struct {
    string        name;
    logic [W-1:0] x, y, l1, l2, cos;
    logic         unr, dz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: direct wide-integer evaluation of the formula and its clamping rules.
  function automatic void model(input logic [W-1:0] ix, iy, il1, il2,
                                output logic [W-1:0] c, output logic u, output logic z);
    logic signed [127:0] sx, sy, a1, a2, n, an, d, q;
    logic [W-1:0] t;
    sx = {{96{ix[W-1]}}, ix};
    sy = {{96{iy[W-1]}}, iy};
    a1 = {96'b0, il1};
    a2 = {96'b0, il2};
    n  = sx * sx + sy * sy - a1 * a1 - a2 * a2;
    d  = 2 * a1 * a2;
    u  = 1'b0;
    z  = 1'b0;
    if (d == 0) begin
      z = 1'b1;
      c = '0;
    end else begin
      an = (n < 0) ? -n : n;
      if (an > d) begin
        u = 1'b1;
        t = W'(1) << F;
      end else begin
        q = (an << F) / d;
        t = q[W-1:0];
      end
      c = (n < 0) ? -t : t;
    end
  endfunction

  task automatic launch(input logic [W-1:0] ix, iy, il1, il2);
    @(negedge clk);
    x = ix; y = iy; l1 = il1; l2 = il2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ready_low_after_accept", {63'b0, ready}, 64'd0);
    chk("done_single_cycle", {63'b0, done}, 64'd0);
  endtask

  // Waits for done with a cycle budget; optionally pokes start (with junk operands) so it is sampled at edges inj_a/inj_b.
  task automatic await_done(input int inj_a, input int inj_b, output int lat, output logic ok);
    lat = 0;
    ok  = 1'b0;
    while (lat < 60 && !ok) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == LAT - 1) chk("cos_held_until_done", 64'(cos_out), 64'(exp_prev));
      if (done) ok = 1'b1;
      else if (lat == inj_a - 1 || lat == inj_b - 1) begin
        start = 1'b1;
        x = $urandom; y = $urandom; l1 = $urandom; l2 = $urandom;
      end else start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [W-1:0] ix, iy, il1, il2,
                           input int inj_a, input int inj_b);
    int           lat;
    logic         ok, eu, ez;
    logic [W-1:0] ec;
    model(ix, iy, il1, il2, ec, eu, ez);
    launch(ix, iy, il1, il2);
    await_done(inj_a, inj_b, lat, ok);
    chk({name, "_done_seen"}, {63'b0, ok}, 64'd1);
    chk({name, "_latency"}, 64'(lat), 64'(LAT));
    chk({name, "_cos"}, 64'(cos_out), 64'(ec));
    chk({name, "_unreachable"}, {63'b0, unreachable}, {63'b0, eu});
    chk({name, "_div_zero"}, {63'b0, div_zero}, {63'b0, ez});
    chk({name, "_ready_with_done"}, {63'b0, ready}, 64'd1);
    exp_prev = ec;
  endtask

  initial begin
    vec_t vecs[10];
    int   dcount;
    int   lat;
    logic ok;

    vecs[0] = '{"reach_full",   32'h00020000, 32'h0,        32'h00010000, 32'h00010000, 32'h00010000, 1'b0, 1'b0};
    vecs[1] = '{"cos_0p3125",   32'h00020000, 32'h00018000, 32'h00020000, 32'h00010000, 32'h00005000, 1'b0, 1'b0};
    vecs[2] = '{"fold_neg1",    32'h0,        32'h0,        32'h00010000, 32'h00010000, 32'hFFFF0000, 1'b0, 1'b0};
    vecs[3] = '{"too_far",      32'h00030000, 32'h0,        32'h00010000, 32'h00010000, 32'h00010000, 1'b1, 1'b0};
    vecs[4] = '{"l2_zero",      32'h00012345, 32'h00000777, 32'h00010000, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[5] = '{"l1_zero",      32'hFFFB0000, 32'h00001000, 32'h0,        32'h00020000, 32'h0,        1'b0, 1'b1};
    vecs[6] = '{"too_near",     32'h0,        32'h0,        32'h00030000, 32'h00010000, 32'hFFFF0000, 1'b1, 1'b0};
    vecs[7] = '{"right_angle",  32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h0,        1'b0, 1'b0};
    vecs[8] = '{"minus_half",   32'h00010000, 32'h0,        32'h00010000, 32'h00010000, 32'hFFFF8000, 1'b0, 1'b0};
    vecs[9] = '{"trunc_sixth",  32'h00030000, 32'h0,        32'h00030000, 32'h00010000, 32'hFFFFD556, 1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; x = '0; y = '0; l1 = '0; l2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {63'b0, ready}, 64'd1);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_cos", 64'(cos_out), 64'd0);
    chk("reset_flags", {62'b0, unreachable, div_zero}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table against hand-derived constants.
    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].x, vecs[i].y, vecs[i].l1, vecs[i].l2);
      await_done(0, 0, lat, ok);
      chk({vecs[i].name, "_done_seen"}, {63'b0, ok}, 64'd1);
      chk({vecs[i].name, "_latency"}, 64'(lat), 64'(LAT));
      chk({vecs[i].name, "_cos"}, 64'(cos_out), 64'(vecs[i].cos));
      chk({vecs[i].name, "_unreachable"}, {63'b0, unreachable}, {63'b0, vecs[i].unr});
      chk({vecs[i].name, "_div_zero"}, {63'b0, div_zero}, {63'b0, vecs[i].dz});
      exp_prev = vecs[i].cos;
    end

    // Start pulses mid-run with different operands must be ignored.
    run_check("ignored_starts", 32'h00020000, 32'h00018000, 32'h00020000, 32'h00010000, 3, 10);
    // Start on the cycle right after done is accepted.
    run_check("back_to_back", 32'h00010000, 32'h0, 32'h00010000, 32'h00010000, 0, 0);
    run_check("pre_abort", 32'h00030000, 32'h0, 32'h00010000, 32'h00010000, 0, 0);

    // Reset at edge 12 of a run aborts it.
    launch(32'h00020000, 32'h00018000, 32'h00020000, 32'h00010000);
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_ready", {63'b0, ready}, 64'd1);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_cos", 64'(cos_out), 64'd0);
    chk("abort_flags", {62'b0, unreachable, div_zero}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_prev = '0;
    dcount = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    run_check("after_abort", 32'h00020000, 32'h00018000, 32'h00020000, 32'h00010000, 0, 0);

    // Random operands against the reference model.
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] rxv, ryv, r1, r2;
      if (k % 4 == 3) begin
        rxv = $urandom; ryv = $urandom; r1 = $urandom; r2 = $urandom;
      end else begin
        rxv = {{12{1'b0}}, 20'($urandom)};
        ryv = {{12{1'b0}}, 20'($urandom)};
        if ($urandom_range(0, 1) == 1) rxv = -rxv;
        if ($urandom_range(0, 1) == 1) ryv = -ryv;
        r1 = W'($urandom_range(0, 32'h40000));
        r2 = W'($urandom_range(0, 32'h40000));
        if (k % 10 == 5) r2 = '0;
      end
      run_check("random", rxv, ryv, r1, r2, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
